// File: rtl/bbc_adc_core.sv
// ============================================================================
// Module   : bbc_adc_core
// Purpose  : uPD7002-style 4-channel ADC for the BBC Micro SHEILA page
//            (&FEC0-&FEC3). Joystick axes arrive as 8-bit digital values;
//            conversion time is counted in CLKEN ticks and completion is
//            signalled on the active-low EOC_N line toward the system VIA.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK32M_I      in   system clock, rising edge
//   reset_n       in   synchronous active-low reset
//   CLKEN         in   bus/timebase clock enable (one CLK32M_I cycle wide)
//   ENABLE        in   chip select (address already decoded)
//   R_nW          in   1 = read, 0 = write
//   A[1:0]        in   register select
//   DI[7:0]       in   CPU write data
//   DO[7:0]       out  CPU read data (combinational, 0x00 when not selected)
//   ch0..ch3[7:0] in   channel inputs, unsigned, quasi-static
//   EOC_N         out  end of conversion, active low, registered
// ----------------------------------------------------------------------------
// Build option
//   ADC_FAST_CONV_EN : when defined, every conversion takes 2 CLKEN ticks
//                      regardless of mode or CONV_TICKS_* parameters.
// ============================================================================
`default_nettype none

module bbc_adc_core #(
  parameter int CONV_TICKS_8  = 4000,
  parameter int CONV_TICKS_12 = 10000
) (
  input  logic       CLK32M_I,
  input  logic       reset_n,
  input  logic       CLKEN,
  input  logic       ENABLE,
  input  logic       R_nW,
  input  logic [1:0] A,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic [7:0] ch0,
  input  logic [7:0] ch1,
  input  logic [7:0] ch2,
  input  logic [7:0] ch3,
  output logic       EOC_N
);

  localparam int CW = 14;

  // Counter load values: a conversion of N ticks loads N-1 and completes on
  // the tick that finds the counter at zero.
`ifdef ADC_FAST_CONV_EN
  localparam logic [CW-1:0] LOAD_8  = CW'(1);
  localparam logic [CW-1:0] LOAD_12 = CW'(1);
`else
  localparam logic [CW-1:0] LOAD_8  = CW'(CONV_TICKS_8 - 1);
  localparam logic [CW-1:0] LOAD_12 = CW'(CONV_TICKS_12 - 1);
`endif

  logic [3:0]    ctrl;
  logic [15:0]   result;
  logic          busy;
  logic          eoc;
  logic [CW-1:0] count;

  logic          start_wr;
  logic          data_rd;
  logic          done;
  logic [7:0]    sel_v;
  logic [15:0]   done_result;
  logic          eoc_next;

  assign start_wr = CLKEN & ENABLE & ~R_nW & (A == 2'd0);
  assign data_rd  = CLKEN & ENABLE &  R_nW & ((A == 2'd1) | (A == 2'd2));
  assign done     = CLKEN & busy & (count == '0);

  // Channel is sampled on the completing edge, not at start.
  always_comb begin
    sel_v = ch0;
    case (ctrl[1:0])
      2'd0:    sel_v = ch0;
      2'd1:    sel_v = ch1;
      2'd2:    sel_v = ch2;
      default: sel_v = ch3;
    endcase
  end

  // 12-bit mode replicates the upper nibble into bits 7:4 so the 8-bit
  // input spans the 12-bit range; 8-bit mode leaves the low byte clear.
  assign done_result = {sel_v, (ctrl[3] ? sel_v[7:4] : 4'h0), 4'h0};

  // Priority: a data read clears, a completion sets, a start write clears.
  // A completion on the same tick as a data read therefore stays visible.
  always_comb begin
    eoc_next = eoc;
    if (data_rd)  eoc_next = 1'b0;
    if (done)     eoc_next = 1'b1;
    if (start_wr) eoc_next = 1'b0;
  end

  always_ff @(posedge CLK32M_I) begin
    if (!reset_n) begin
      ctrl   <= 4'h0;
      result <= 16'h0000;
      busy   <= 1'b0;
      eoc    <= 1'b0;
      count  <= '0;
      EOC_N  <= 1'b1;
    end else begin
      eoc   <= eoc_next;
      EOC_N <= ~eoc_next;
      // Result still captures a completing conversion even if a start
      // write on the same tick restarts the converter.
      if (done) result <= done_result;
      if (start_wr) begin
        ctrl  <= DI[3:0];
        busy  <= 1'b1;
        count <= DI[3] ? LOAD_12 : LOAD_8;
      end else if (CLKEN && busy) begin
        if (count == '0) busy  <= 1'b0;
        else             count <= count - 1'b1;
      end
    end
  end

  // Status bit 7 is the conversion-complete flag, bit 6 is "not busy".
  always_comb begin
    DO = 8'h00;
    if (ENABLE) begin
      case (A)
        2'd0:    DO = {eoc, ~busy, result[15:14], ctrl[3], ctrl[2], ctrl[1:0]};
        2'd1:    DO = result[15:8];
        2'd2:    DO = result[7:0];
        default: DO = 8'h00;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bbc_adc_core.sv
// ============================================================================
// Module   : tb_bbc_adc_core
// Purpose  : Self-checking bench for bbc_adc_core. A deadline-based
//            reference model predicts register reads and completion ticks;
//            monitors compare DUT outputs against queued expectations.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bbc_adc_core;

  localparam int P8  = 5;
  localparam int P12 = 9;
`ifdef ADC_FAST_CONV_EN
  localparam int T8  = 2;
  localparam int T12 = 2;
`else
  localparam int T8  = P8;
  localparam int T12 = P12;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       CLKEN, ENABLE, R_nW;
  logic [1:0] A;
  logic [7:0] DI, DO;
  logic [7:0] ch [4];
  logic       EOC_N;

  bbc_adc_core #(.CONV_TICKS_8(P8), .CONV_TICKS_12(P12)) dut (
    .CLK32M_I(clk), .reset_n(reset_n), .CLKEN(CLKEN), .ENABLE(ENABLE),
    .R_nW(R_nW), .A(A), .DI(DI), .DO(DO),
    .ch0(ch[0]), .ch1(ch[1]), .ch2(ch[2]), .ch3(ch[3]), .EOC_N(EOC_N)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    logic       eocn;
  } rd_t;

  rd_t rd_q [$];
  int  done_q [$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  tick    = 0;
  logic probe  = 1'b0;

  // Reference model state
  logic [3:0]  m_ctrl;
  logic [15:0] m_result;
  bit          m_busy, m_eoc;
  int          m_deadline;

  function automatic logic [7:0] model_do(input logic [1:0] a, input bit en);
    logic [7:0] r;
    r = 8'h00;
    if (en) begin
      case (a)
        2'd0: r = {m_eoc, ~m_busy, m_result[15:14], m_ctrl};
        2'd1: r = m_result[15:8];
        2'd2: r = m_result[7:0];
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_ctrl = 4'h0; m_result = 16'h0; m_busy = 0; m_eoc = 0; m_deadline = 0;
    done_q.delete();
  endfunction

  // Advance the model by one CLKEN tick with the given bus access.
  function automatic void model_step(input bit en, input bit rnw,
                                     input logic [1:0] a, input logic [7:0] d);
    int cur;
    bit was, fin;
    logic [7:0] v;
    cur = tick + 1;
    was = m_eoc;
    fin = 0;
    if (m_busy && cur == m_deadline) begin
      v = ch[m_ctrl[1:0]];
      m_result = {v, 8'h00};
      if (m_ctrl[3]) m_result[7:4] = v[7:4];
      m_busy = 0;
      fin = 1;
    end
    if (fin) m_eoc = 1;
    else if (en && rnw && (a == 2'd1 || a == 2'd2)) m_eoc = 0;
    if (en && !rnw && a == 2'd0) begin
      m_ctrl = d[3:0];
      m_busy = 1;
      m_eoc = 0;
      m_deadline = cur + (d[3] ? T12 : T8);
    end
    if (!was && m_eoc) done_q.push_back(cur);
  endfunction

  // One CLKEN tick (one enabled cycle followed by idle cycles).
  task automatic op(input bit en, input bit rnw, input logic [1:0] a,
                    input logic [7:0] d);
    rd_t it;
    @(negedge clk);
    ENABLE = en; R_nW = rnw; A = a; DI = d; CLKEN = 1'b1;
    if (rnw) begin
      it.a = a; it.d = model_do(a, en); it.eocn = ~m_eoc;
      rd_q.push_back(it);
      probe = 1'b1;
    end
    @(posedge clk); #1;
    CLKEN = 1'b0; ENABLE = 1'b0; R_nW = 1'b1; probe = 1'b0;
    model_step(en, rnw, a, d);
    tick++;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; CLKEN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1; CLKEN = 1'b0;
    model_reset();
  endtask

  // Read monitor: compares DO / EOC_N whenever a read is presented.
  always begin
    @(negedge clk); #2;
    if (probe) begin
      n_tests++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_queue: DUT read with no expectation queued");
      end else begin
        rd_t e;
        e = rd_q.pop_front();
        if (DO !== e.d || EOC_N !== e.eocn) begin
          n_fail++;
          $display("FAIL rd_A%0d tick %0d: DO=%02h EOC_N=%0b, required DO=%02h EOC_N=%0b",
                   e.a, tick, DO, EOC_N, e.d, e.eocn);
        end
      end
    end
  end

  // Completion monitor: every EOC_N falling edge must match a predicted tick.
  logic eoc_prev = 1'b1;
  always @(negedge clk) begin
    if (reset_n && eoc_prev && !EOC_N) begin
      n_tests++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL eoc_unexpected: EOC_N fell at tick %0d, required no completion", tick);
      end else begin
        int t;
        t = done_q.pop_front();
        if (t != tick) begin
          n_fail++;
          $display("FAIL eoc_tick: completion at tick %0d, required tick %0d", tick, t);
        end
      end
    end
    eoc_prev = EOC_N;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; CLKEN = 1'b0; ENABLE = 1'b0; R_nW = 1'b1; A = 2'd0; DI = 8'h00;
    for (int i = 0; i < 4; i++) ch[i] = 8'h00;
    model_reset();
    do_reset();

    // Reset state
    op(1, 1, 2'd0, 8'h00);
    op(0, 1, 2'd0, 8'h00);

    // 8-bit conversion on channel 2
    ch[2] = 8'hA7;
    op(1, 0, 2'd0, 8'h02);
    for (int i = 0; i < T8 + 2; i++) op(1, 1, 2'd0, 8'h00);
    op(1, 1, 2'd1, 8'h00);
    op(1, 1, 2'd0, 8'h00);
    op(1, 1, 2'd2, 8'h00);

    // 12-bit conversion on channel 1
    ch[1] = 8'h3C;
    op(1, 0, 2'd0, 8'h09);
    for (int i = 0; i < T12 + 1; i++) op(1, 1, 2'd0, 8'h00);
    op(1, 1, 2'd2, 8'h00);
    op(1, 1, 2'd1, 8'h00);
    op(1, 1, 2'd0, 8'h00);

    // Ignored writes to A=1..3
    op(1, 0, 2'd1, 8'hFF);
    op(1, 0, 2'd3, 8'hFF);
    op(1, 1, 2'd0, 8'h00);

    // Abort and restart: ch0 8-bit, then ch3 mid-conversion
    ch[0] = 8'h11; ch[3] = 8'h55;
    op(1, 0, 2'd0, 8'h00);
    op(1, 1, 2'd0, 8'h00);
    op(1, 0, 2'd0, 8'h03);
    for (int i = 0; i < T8 + 2; i++) op(1, 1, 2'd0, 8'h00);
    op(1, 1, 2'd1, 8'h00);
    op(1, 1, 2'd2, 8'h00);

    // Reset mid-conversion: no completion afterwards
    op(1, 0, 2'd0, 8'h0A);
    op(1, 1, 2'd0, 8'h00);
    do_reset();
    for (int i = 0; i < T12 + 3; i++) op(1, 1, 2'd0, 8'h00);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r <= 1)      op(1, 0, 2'd0, 8'($urandom));
      else if (r == 2) op(1, 0, 2'($urandom_range(1, 3)), 8'($urandom));
      else if (r <= 8) op($urandom_range(0, 7) != 0, 1, 2'($urandom), 8'h00);
      else if (r == 9) op(0, 1, 2'd0, 8'h00);
      else if (r == 10 && !m_busy) begin
        ch[$urandom_range(0, 3)] = 8'($urandom);
        op(1, 1, 2'd0, 8'h00);
      end else op(1, 1, 2'($urandom_range(1, 2)), 8'h00);
    end

    repeat (4) @(posedge clk);
    n_tests++;
    if (done_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d completions and %0d reads outstanding, required 0 and 0",
               done_q.size(), rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
